// File: rtl/bit_stream_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bit_stream_serializer_if                                        |
// | Brief    : Word handshake and serial-output bundle for the serializer.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             dout;
    logic             dout_valid;
    logic             word_done;
    logic             busy;

    // master = word source / bit sink, slave = serializer
    modport master (
        output in_valid, in_data,
        input  in_ready, dout, dout_valid, word_done, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, dout, dout_valid, word_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_stream_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bit_stream_serializer                                           |
// | Brief    : WIDTH-bit words in over valid/ready, MSB-first serial bits out, |
// |            with a one-word holding buffer. Option macro: SER_PARITY_EN.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bit_stream_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  wire                     clk,
    input  wire                     rst,
    bit_stream_serializer_if.slave  bus
);
    localparam int                 CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

    state_t             state_q, state_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
`ifdef SER_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               accept;
    logic               load;
    logic               dout_c, dout_valid_c, word_done_c;

    // in_ready deliberately ignores in_valid so the source sees no comb loop
    assign bus.in_ready = !hold_full_q && !rst;
    assign accept       = bus.in_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                if (bitcnt_q == LAST) begin
                    bitcnt_d = '0;
`ifdef SER_PARITY_EN
                    state_d  = S_PARITY;
`else
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Load only happens with the buffer full, accept only with it empty,
        // so the two never collide on the same edge.
        if (load) begin
            shreg_d     = hold_data_q;
            bitcnt_d    = '0;
            hold_full_d = 1'b0;
            state_d     = S_SHIFT;
`ifdef SER_PARITY_EN
            parity_d    = ^hold_data_q;
`endif
        end
        if (accept) begin
            hold_data_d = bus.in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Outputs decode registered state only
    always_comb begin
        dout_c       = IDLE_LEVEL;
        dout_valid_c = 1'b0;
        word_done_c  = 1'b0;
        case (state_q)
            S_SHIFT: begin
                dout_c       = shreg_q[WIDTH-1];
                dout_valid_c = 1'b1;
`ifndef SER_PARITY_EN
                word_done_c  = (bitcnt_q == LAST);
`endif
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                dout_c       = parity_q;
                dout_valid_c = 1'b1;
                word_done_c  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.dout       = dout_c;
    assign bus.dout_valid = dout_valid_c;
    assign bus.word_done  = word_done_c;
    assign bus.busy       = (state_q != S_IDLE) || hold_full_q;
endmodule
`default_nettype wire

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-to-serial front end that produces the single-bit `din` stream consumed by the team's overlapping sequence detectors, such as the 110110 Mealy detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- A one-word holding buffer lets consecutive words stream with no idle bit-cycles between them.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- IDLE_LEVEL, 0, value driven on dout when no bit is being shifted (0 or 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a word to transfer.
- in_ready  output  1  holding buffer can accept a word this cycle.
- in_data  input  WIDTH  parallel word; bit WIDTH-1 is sent first.
- dout  output  1  serial bit; connects to detector din.
- dout_valid  output  1  dout carries a live data (or parity) bit this cycle.
- word_done  output  1  one-cycle pulse coincident with the final bit of a word.
- busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - Sampled only at the clk rising edge.
  - Clears hold_full, the shift register, the bit counter and the FSM state (IDLE).
  - Outputs after reset: dout=IDLE_LEVEL, dout_valid=0, word_done=0, busy=0.
  - in_ready is forced 0 while rst=1; it is 1 in the first cycle after rst deasserts.
- Reset mid-word discards the partial word and any buffered word; no further bits of them are emitted.
- Handshake:
  - in_ready = !hold_full && !rst. It has no combinational dependence on in_valid.
  - Transfer occurs on an edge where in_valid && in_ready. At that edge in_data is captured into hold_data and hold_full is set.
  - in_data is don't-care when in_valid=0.
- FSM states: IDLE, SHIFT (plus PARITY under the optional feature).
  - IDLE: if hold_full, load hold_data into the shift register, clear hold_full, set bitcnt=0, go to SHIFT.
  - SHIFT: dout = shreg[WIDTH-1] and dout_valid=1. Each edge shifts left by one and increments bitcnt.
  - When bitcnt==WIDTH-1 in SHIFT:
    - word_done=1 in that cycle.
    - At that edge, if hold_full: reload from the buffer, clear hold_full, bitcnt=0, stay in SHIFT (no gap).
    - Otherwise go to IDLE.
- dout and dout_valid are driven from registers (no combinational path from inputs). When dout_valid=0, dout=IDLE_LEVEL.
- Latency: a word accepted at edge k has its first bit on dout in the cycle after edge k+1 (IDLE case).
- Throughput: continuous streaming at 1 bit/clk when the source re-presents a word within WIDTH-1 cycles of in_ready rising.
- Simultaneous events: a buffer load and a new accept cannot coincide, because in_ready=0 while hold_full=1. The buffer reopens the cycle after it is loaded.
- bitcnt width is $clog2(WIDTH). It never exceeds WIDTH-1.
- busy = (state!=IDLE) || hold_full.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - After bit 0 of each word, the FSM enters PARITY for one cycle.
  - In PARITY, dout = XOR of all WIDTH data bits (even parity) and dout_valid=1.
  - word_done moves to the parity cycle.
  - A buffered word reloads at the parity-cycle edge.
  - Throughput becomes WIDTH+1 clocks per word.
- Undefined: no PARITY state, no parity logic; behaviour exactly as above.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, dout_valid=0, dout=IDLE_LEVEL throughout, and no word is accepted.
- Single word 8'hDB at edge k -> dout = 1,1,0,1,1,0,1,1 in cycles k+2..k+9; dout_valid=1 only in those cycles; word_done in cycle k+9; busy drops in cycle k+10.
- Back-to-back 8'hB6 then 8'hD8, in_valid held high -> 16 consecutive bits 10110110 11011000 with dout_valid never low; word_done in bits 8 and 16.
- Backpressure: present a third word while the buffer is full -> in_ready=0 until the reload edge. The word is held by the source and transmitted intact, with none lost or duplicated.
- Reset after the 3rd bit of 8'hFF, with 8'h00 buffered -> dout_valid=0 on the next cycle, busy=0, and neither word resumes.
- SER_PARITY_EN build, word 8'h07 -> 00000111 then parity bit 1; word_done on the 9th bit.
